// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs
//   Registered N-to-log2(N) priority encoder with a valid/ready output handshake.
//   The encoder picks one winner from a bank of request lines and holds that
//   result until the consumer takes it.
//   - mode = 0: fixed priority. The lowest set index wins.
//   - mode = 1: round-robin. The search starts at an internal pointer. The
//     pointer moves to one past the last consumed index.
//   Once a result is held, later changes on req and mode have no effect until
//   the handshake. A handshake in the same cycle as a non-zero req captures the
//   next result immediately, so the encoder can deliver one result per cycle.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous, active-high reset
//   req      in   N  request lines, bit k = source k requesting
//   mode     in   1  0 = fixed priority, 1 = round-robin
//   o_ready  in   1  consumer accepts the current result
//   o_valid  out  1  o_idx / o_multi hold a valid result
//   o_idx    out  W  index of the winning request
//   o_multi  out  1  more than one request was set at capture
module prio_encoder_hs #(
    parameter int N = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N-1:0]                          req,
    input  logic                                  mode,
    input  logic                                  o_ready,
    output logic                                  o_valid,
    output logic [((N <= 1) ? 1 : $clog2(N))-1:0] o_idx,
    output logic                                  o_multi
);

    localparam int W = (N <= 1) ? 1 : $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   ptr;

    logic           handshake;
    logic [W-1:0]   ptr_after;
    logic [W-1:0]   ptr_eff;
    logic           capture;
    logic [W-1:0]   win_idx;
    logic           win_multi;

    // Returns the lowest set index of r.
    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] r);
        logic [W-1:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) res = W'(i);
        end
        return res;
    endfunction

    // Returns the first set index of r, searching upward from start and
    // wrapping past N-1. The loop runs downward, so the hit closest to start
    // is the last assignment.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [W-1:0] start);
        logic [W-1:0] res;
        int           p;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (r[p]) res = W'(p);
        end
        return res;
    endfunction

    always_comb begin
        handshake = o_valid && o_ready;
        ptr_after = (o_idx == W'(N - 1)) ? '0 : o_idx + W'(1);
        // A capture that coincides with a handshake searches from the
        // pointer the handshake is installing, not from the stale one.
        ptr_eff   = handshake ? ptr_after : ptr;
        capture   = (req != '0) && ((state == IDLE) || handshake);
        win_idx   = mode ? rr_pick(req, ptr_eff) : lowest_set(req);
        // Clearing the lowest set bit leaves a non-zero value only when
        // at least two bits were set.
        win_multi = (req & (req - N'(1))) != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_idx   <= '0;
            o_multi <= 1'b0;
            ptr     <= '0;
        end else begin
            if (handshake) ptr <= ptr_after;
            if (capture) begin
                state   <= HOLD;
                o_valid <= 1'b1;
                o_idx   <= win_idx;
                o_multi <= win_multi;
            end else if (handshake) begin
                state   <= IDLE;
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/prio_encoder_hs.md
Name: prio_encoder_hs

Overview:
- Parametrised, registered N-to-log2(N) encoder; successor to the 2-to-1 encoder.
- Adds selectable fixed-priority or round-robin encoding, a multiple-request flag, and a valid/ready output handshake that holds each result until it is consumed.
- Sits between a bank of request lines and a single downstream consumer, e.g. an arbiter front end or interrupt-source encoder.

Parameters:
- N, 4, number of request inputs; legal range 1..64, need not be a power of two.
- W, derived as max(1, ceil(log2(N))), width of o_idx; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines; bit k set = source k requesting.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- o_ready  input  1  downstream accepts the current result.
- o_valid  output  1  o_idx/o_multi hold a valid result.
- o_idx  output  W  encoded index of the winning request.
- o_multi  output  1  more than one req bit was set when the result was captured.

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_valid=0, o_idx=0, o_multi=0, rr pointer ptr=0, state IDLE.
  - Reset overrides every other input in that cycle.
  - Reset mid-HOLD discards the pending result without a handshake.
- State IDLE (o_valid=0):
  - If req!=0 at a clk edge, capture the result and go to HOLD. o_valid=1 from the next cycle (1-cycle latency).
  - If req==0, stay in IDLE; outputs unchanged.
- Winner selection, evaluated on the req and mode values sampled at the capture edge:
  - mode=0: lowest set bit index.
  - mode=1: first set bit searching upward from ptr, i.e. ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - o_multi=1 iff popcount(req)>=2 at capture.
- State HOLD (o_valid=1):
  - o_idx and o_multi stay frozen. Changes on req or mode are ignored until the handshake.
  - o_ready=0: stay in HOLD.
  - Handshake = o_valid&&o_ready at a clk edge:
    - ptr <= (o_idx==N-1) ? 0 : o_idx+1, in both modes.
    - If req!=0 in the same cycle, capture a new result (using the updated-ptr rule: search starts at the new ptr) and stay in HOLD. This gives back-to-back results with no bubble.
    - Otherwise go to IDLE with o_valid=0.
- ptr width is W. ptr wraps at N-1 to 0, never reaching values >= N.
- N=1: o_idx is always 0, ptr is always 0, o_multi is always 0.
- o_ready while o_valid=0 is ignored; ptr does not move.
- Throughput: one result per cycle while req stays non-zero and o_ready=1.
- All outputs are driven directly from registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset/idle, N=4: rst=1 for 2 cycles with req=4'b1111 -> o_valid=0, o_idx=0, o_multi=0. Release rst with req=0 for 5 cycles -> o_valid stays 0.
- Fixed priority, latency and hold: mode=0, o_ready=0, req=4'b1010 at edge t.
  - At t+1: o_valid=1, o_idx=1, o_multi=1.
  - Change req to 4'b0001 for 3 cycles -> o_idx stays 1.
  - Assert o_ready for one cycle with req=0 -> next cycle o_valid=0.
- Round-robin rotation: mode=1, o_ready=1, req held at 4'b1111 -> o_idx sequence 0,1,2,3,0 on consecutive cycles, o_valid continuously 1, o_multi=1 throughout.
- Round-robin skip and wrap:
  - mode=1, ptr=3 (reached after granting index 2), req=4'b0101 -> o_idx=0, then ptr=1.
  - Next, with req=4'b0101 -> o_idx=2.
  - Single request req=4'b1000 -> o_idx=3, o_multi=0.
- Backpressure with mode switch: mode=1, capture o_idx=2 with o_ready=0. Toggle mode and req for 4 cycles -> o_idx=2 stable. Handshake -> ptr=3.
- Reset mid-HOLD and non-power-of-two size:
  - N=4: rst asserted while o_valid=1 -> next cycle o_valid=0, and the next RR search starts from ptr=0.
  - Separate N=5 instance, mode=1, req=5'b11111 -> o_idx sequence 0..4,0 (wrap at 4).
